// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, bus width and sequencer states.
// Imported by the instruction sequencer and its program buffer.
package cpu_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [7:0] ADD                 = 8'h01;
  localparam logic [7:0] SUB                 = 8'h02;
  localparam logic [7:0] ADD_IMM             = 8'h03;
  localparam logic [7:0] MUL                 = 8'h04;
  localparam logic [7:0] TENSOR_CORE_OPERATE = 8'h05;
  localparam logic [7:0] LOAD                = 8'h06;
  localparam logic [7:0] STORE               = 8'h07;
  localparam logic [7:0] NOP                 = 8'h08;
  localparam logic [7:0] JUMP                = 8'h09;
  localparam logic [7:0] BRANCH              = 8'h0A;
  localparam logic [7:0] HALT                = 8'h0B;
  localparam logic [7:0] RESET               = 8'h0C;

  localparam logic [BUS_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0008;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT_TENSOR,
    SEQ_DONE
  } sequencer_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Program buffer: synchronous write port, asynchronous read port.
// Contents are never cleared by reset.
module instruction_memory
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clock_in,
  input  logic                 write_enable_in,
  input  logic [AW-1:0]        write_address_in,
  input  logic [BUS_WIDTH-1:0] write_data_in,
  input  logic [AW-1:0]        read_address_in,
  output logic [BUS_WIDTH-1:0] read_data_out
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  // Store one word per enabled cycle.
  always_ff @(posedge clock_in) begin
    if (write_enable_in)
      mem[write_address_in] <= write_data_in;
  end

  assign read_data_out = mem[read_address_in];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues program words to the cpu one per cycle, holding NOPs
// while a tensor core operation is outstanding.
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_MEM_DEPTH = 64,
  parameter int ADDR_WIDTH      = $clog2(INSTR_MEM_DEPTH),
  parameter int OPERATE_TIMEOUT = 32
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  program_write_enable_in,
  input  logic [ADDR_WIDTH-1:0] program_write_address_in,
  input  logic [BUS_WIDTH-1:0]  program_write_data_in,
  input  logic [ADDR_WIDTH:0]   program_length_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  tensor_core_done_in,
  output logic [BUS_WIDTH-1:0]  current_instruction_out,
  output logic [ADDR_WIDTH-1:0] program_counter_out,
  output logic                  busy_out,
  output logic                  halted_out,
  output logic                  timeout_error_out
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(OPERATE_TIMEOUT) + 1;

  sequencer_state_t     state_q;
  logic [LW-1:0]        pc_q;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        start_len;
  logic [CW-1:0]        stall_q;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 mem_we;

  // pc carries one extra bit so a full-depth program never wraps.
  assign start_len = (program_length_in > LW'(INSTR_MEM_DEPTH))
                   ? LW'(INSTR_MEM_DEPTH) : program_length_in;

  assign mem_we = program_write_enable_in &&
                  (state_q == SEQ_IDLE || state_q == SEQ_DONE);

  assign program_counter_out = pc_q[ADDR_WIDTH-1:0];

  instruction_memory #(
    .DEPTH (INSTR_MEM_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_mem (
    .clock_in         (clock_in),
    .write_enable_in  (mem_we),
    .write_address_in (program_write_address_in),
    .write_data_in    (program_write_data_in),
    .read_address_in  (pc_q[ADDR_WIDTH-1:0]),
    .read_data_out    (rd_data)
  );

  // Sequencer FSM with registered instruction, pc and status outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q                 <= SEQ_IDLE;
      current_instruction_out <= NOP_INSTRUCTION;
      pc_q                    <= '0;
      len_q                   <= '0;
      stall_q                 <= '0;
      busy_out                <= 1'b0;
      halted_out              <= 1'b0;
      timeout_error_out       <= 1'b0;
    end else if (abort_in) begin
      state_q                 <= SEQ_IDLE;
      current_instruction_out <= NOP_INSTRUCTION;
      pc_q                    <= '0;
      stall_q                 <= '0;
      busy_out                <= 1'b0;
      halted_out              <= 1'b0;
    end else begin
      unique case (state_q)
        SEQ_IDLE, SEQ_DONE: begin
          current_instruction_out <= NOP_INSTRUCTION;
          if (start_in) begin
            len_q <= start_len;
            pc_q  <= '0;
            if (start_len == '0) begin
              state_q    <= SEQ_DONE;
              busy_out   <= 1'b0;
              halted_out <= 1'b1;
            end else begin
              state_q    <= SEQ_ISSUE;
              busy_out   <= 1'b1;
              halted_out <= 1'b0;
            end
          end
        end
        SEQ_ISSUE: begin
          current_instruction_out <= rd_data;
          pc_q                    <= pc_q + LW'(1);
          if (rd_data[7:0] == TENSOR_CORE_OPERATE) begin
            state_q <= SEQ_WAIT_TENSOR;
            stall_q <= '0;
          end else if (pc_q == len_q - LW'(1)) begin
            state_q    <= SEQ_DONE;
            busy_out   <= 1'b0;
            halted_out <= 1'b1;
          end
        end
        SEQ_WAIT_TENSOR: begin
          current_instruction_out <= NOP_INSTRUCTION;
          stall_q                 <= stall_q + CW'(1);
          if (tensor_core_done_in) begin
            if (pc_q == len_q) begin
              state_q    <= SEQ_DONE;
              busy_out   <= 1'b0;
              halted_out <= 1'b1;
            end else begin
              state_q <= SEQ_ISSUE;
            end
          end else if (stall_q == CW'(OPERATE_TIMEOUT - 1)) begin
            timeout_error_out <= 1'b1;
            state_q           <= SEQ_DONE;
            busy_out          <= 1'b0;
            halted_out        <= 1'b1;
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed scenarios plus random
// programs checked against an expected-trace model.
module tb_instruction_sequencer;
  import cpu_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TMO   = 32;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          program_write_enable_in;
  logic [AW-1:0] program_write_address_in;
  logic [31:0]   program_write_data_in;
  logic [AW:0]   program_length_in;
  logic          start_in;
  logic          abort_in;
  logic          tensor_core_done_in;
  logic [31:0]   current_instruction_out;
  logic [AW-1:0] program_counter_out;
  logic          busy_out;
  logic          halted_out;
  logic          timeout_error_out;

  instruction_sequencer dut (
    .clock_in                 (clock_in),
    .reset_in                 (reset_in),
    .program_write_enable_in  (program_write_enable_in),
    .program_write_address_in (program_write_address_in),
    .program_write_data_in    (program_write_data_in),
    .program_length_in        (program_length_in),
    .start_in                 (start_in),
    .abort_in                 (abort_in),
    .tensor_core_done_in      (tensor_core_done_in),
    .current_instruction_out  (current_instruction_out),
    .program_counter_out      (program_counter_out),
    .busy_out                 (busy_out),
    .halted_out               (halted_out),
    .timeout_error_out        (timeout_error_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [31:0] out;
    int          pc;
    bit          busy;
    bit          halted;
    bit          tout;
    bit          done;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] pm [DEPTH];
  bit          m_tout;
  int          dq [$];
  exp_t        tr [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, " out"}, current_instruction_out, e.out);
    chk({tag, " pc"}, 32'(program_counter_out), 32'(e.pc));
    chk({tag, " busy"}, 32'(busy_out), 32'(e.busy));
    chk({tag, " halted"}, 32'(halted_out), 32'(e.halted));
    chk({tag, " tout"}, 32'(timeout_error_out), 32'(e.tout));
  endtask

  function automatic exp_t mk(input logic [31:0] o, input int p,
                              input bit b, input bit h, input bit d);
    exp_t e;
    e.out    = o;
    e.pc     = p;
    e.busy   = b;
    e.halted = h;
    e.tout   = m_tout;
    e.done   = d;
    return e;
  endfunction

  function automatic bit noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    program_write_enable_in  = 1'b1;
    program_write_address_in = AW'(a);
    program_write_data_in    = d;
    step();
    program_write_enable_in  = 1'b0;
    pm[a] = d;
  endtask

  // Expected per-edge trace: start edge, each word, k NOPs per
  // OPERATE (done on the k-th), then idle DONE cycles.
  task automatic build(input int len_raw);
    int len;
    int pcv;
    int k;
    int n;
    bit stop;
    bit last;
    len  = (len_raw > DEPTH) ? DEPTH : len_raw;
    pcv  = 0;
    stop = 0;
    tr.delete();
    tr.push_back(mk(NOP_INSTRUCTION, 0, len != 0, len == 0, noise()));
    for (int i = 0; i < len && !stop; i++) begin
      last = (i == len - 1);
      pcv  = (i + 1) % DEPTH;
      if (pm[i][7:0] == TENSOR_CORE_OPERATE) begin
        k = (dq.size() > 0) ? dq.pop_front() : TMO + 1;
        n = (k > TMO) ? TMO : k;
        tr.push_back(mk(pm[i], pcv, 1, 0, noise()));
        for (int s = 1; s <= n; s++) begin
          if (s == n && k > TMO) begin
            m_tout = 1;
            stop   = 1;
            tr.push_back(mk(NOP_INSTRUCTION, pcv, 0, 1, 0));
          end else if (s == n) begin
            tr.push_back(mk(NOP_INSTRUCTION, pcv, !last, last, 1));
          end else begin
            tr.push_back(mk(NOP_INSTRUCTION, pcv, 1, 0, 0));
          end
        end
      end else begin
        tr.push_back(mk(pm[i], pcv, !last, last, noise()));
      end
    end
    for (int j = 0; j < 3; j++)
      tr.push_back(mk(NOP_INSTRUCTION, pcv, 0, 1, noise()));
  endtask

  task automatic run(input int len_raw, input int upto, input bit busy_wr);
    for (int t = 0; t < tr.size() && t < upto; t++) begin
      start_in            = (t == 0);
      program_length_in   = (AW + 1)'(len_raw);
      tensor_core_done_in = tr[t].done;
      program_write_enable_in  = busy_wr && t > 0 && tr[t-1].busy;
      program_write_address_in = '0;
      program_write_data_in    = 32'hDEAD_BEEF;
      step();
      check_all($sformatf("len%0d t%0d", len_raw, t), tr[t]);
    end
    start_in                = 1'b0;
    tensor_core_done_in     = 1'b0;
    program_write_enable_in = 1'b0;
  endtask

  logic [31:0] w;
  logic [7:0]  ops [11];

  initial begin
    ops = '{ADD, SUB, ADD_IMM, MUL, LOAD, STORE, NOP,
            JUMP, BRANCH, HALT, RESET};
    reset_in                 = 1'b1;
    program_write_enable_in  = 1'b0;
    program_write_address_in = '0;
    program_write_data_in    = '0;
    program_length_in        = '0;
    start_in                 = 1'b0;
    abort_in                 = 1'b0;
    tensor_core_done_in      = 1'b0;
    m_tout                   = 0;
    step();
    step();
    reset_in = 1'b0;
    check_all("reset", mk(NOP_INSTRUCTION, 0, 0, 0, 0));

    // Three ADD_IMM words.
    wr(0, 32'h0011_2203);
    wr(1, 32'h0044_5503);
    wr(2, 32'h0077_8803);
    build(3);
    run(3, 1000, 0);

    // ADD, OPERATE, SUB with done on the 5th stall cycle.
    wr(0, 32'h00A1_B201);
    wr(1, 32'h0000_1105);
    wr(2, 32'h00C3_D402);
    dq = '{5};
    build(3);
    run(3, 1000, 0);

    // OPERATE never completes: timeout, then restart keeps the flag.
    wr(0, 32'h0000_2205);
    wr(1, 32'h0000_3301);
    dq = '{40};
    build(2);
    run(2, 1000, 0);
    wr(0, 32'h0000_4401);
    build(1);
    run(1, 1000, 0);

    // Zero-length program.
    build(0);
    run(0, 1000, 0);

    // Abort with simultaneous start mid-run; busy writes dropped.
    for (int i = 0; i < 8; i++)
      wr(i, 32'h0100_0001 + (32'(i) << 8));
    build(8);
    run(8, 4, 1);
    abort_in          = 1'b1;
    start_in          = 1'b1;
    program_length_in = 7'd8;
    step();
    abort_in = 1'b0;
    start_in = 1'b0;
    check_all("abort", mk(NOP_INSTRUCTION, 0, 0, 0, 0));
    build(1);
    run(1, 1000, 0);

    // Reset during a tensor stall, then a stray done pulse.
    wr(0, 32'h0000_5505);
    wr(1, 32'h0000_6601);
    dq = '{10};
    build(2);
    run(2, 4, 0);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    m_tout   = 0;
    check_all("rst_wait", mk(NOP_INSTRUCTION, 0, 0, 0, 0));
    tensor_core_done_in = 1'b1;
    step();
    tensor_core_done_in = 1'b0;
    check_all("post_rst_done", mk(NOP_INSTRUCTION, 0, 0, 0, 0));
    step();
    check_all("post_rst_idle", mk(NOP_INSTRUCTION, 0, 0, 0, 0));

    // Random programs, lengths (some clamped) and stall lengths.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = $urandom();
        if ($urandom_range(0, 5) == 0)
          w[7:0] = TENSOR_CORE_OPERATE;
        else
          w[7:0] = ops[$urandom_range(0, 10)];
        wr(i, w);
      end
      dq.delete();
      for (int i = 0; i < 70; i++)
        dq.push_back(($urandom_range(0, 9) == 0)
                     ? int'($urandom_range(33, 40))
                     : int'($urandom_range(1, 32)));
      begin
        int len;
        len = (r == 0) ? 127 : int'($urandom_range(0, 70));
        build(len);
        run(len, 1 << 30, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
